// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM command protocol: arbiter states and opcodes.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    WAIT_RD = 3'd3,
    DONE    = 3'd4
  } arb_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Build one 10-bit RAM command word {opcode, payload}.
  function automatic logic [9:0] make_cmd(input logic [1:0] op, input logic [7:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie, the port that was not granted last wins.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant from the request pair and last-grant pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto the single-port RAM, serialising each
// transaction into an address word and a data word, and returning read data.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_wr,
  input  logic [ADDR_SIZE-1:0] m0_addr,
  input  logic [7:0]           m0_wdata,
  output logic                 m0_done,
  output logic [7:0]           m0_rdata,
  output logic                 m0_err,
  input  logic                 m1_req,
  input  logic                 m1_wr,
  input  logic [ADDR_SIZE-1:0] m1_addr,
  input  logic [7:0]           m1_wdata,
  output logic                 m1_done,
  output logic [7:0]           m1_rdata,
  output logic                 m1_err,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid
);

  localparam int CNT_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

  arb_state_e           state_q, state_d;
  logic                 last_q, last_d;
  logic                 sel_q, sel_d;
  logic                 wr_q, wr_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic                 rd_err_q, rd_err_d;
  logic [9:0]           din_q, din_d;
  logic                 rxv_q, rxv_d;
  logic [1:0]           done_q, done_d;
  logic [1:0][7:0]      rdata_q, rdata_d;
  logic [1:0]           err_q, err_d;
  logic [1:0]           gnt;

  rr_arb2 u_arb (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .gnt  (gnt)
  );

  // Next-state, command formatting, timeout and response logic.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    din_d     = din_q;
    rxv_d     = 1'b0;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    err_d     = 2'b00;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          sel_d   = gnt[1];
          wr_d    = gnt[1] ? m1_wr    : m0_wr;
          addr_d  = gnt[1] ? m1_addr  : m0_addr;
          wdata_d = gnt[1] ? m1_wdata : m0_wdata;
          state_d = ADDR;
        end
      end
      ADDR: begin
        din_d   = make_cmd(wr_q ? CMD_WR_ADDR : CMD_RD_ADDR, 8'(addr_q));
        rxv_d   = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        din_d     = make_cmd(wr_q ? CMD_WR_DATA : CMD_RD_DATA, wr_q ? wdata_q : 8'h00);
        rxv_d     = 1'b1;
        rd_data_d = 8'h00;
        rd_err_d  = 1'b0;
        if (wr_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (ram_tx_valid) begin
          rd_data_d = ram_dout;
          state_d   = DONE;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT)) begin
          rd_data_d = 8'h00;
          rd_err_d  = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        done_d[sel_q] = 1'b1;
        if (!wr_q) begin
          rdata_d[sel_q] = rd_data_q;
          err_d[sel_q]   = rd_err_q;
        end
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      cnt_q     <= '0;
      rd_data_q <= 8'h00;
      rd_err_q  <= 1'b0;
      din_q     <= 10'h000;
      rxv_q     <= 1'b0;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
      din_q     <= din_d;
      rxv_q     <= rxv_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign ram_din      = din_q;
  assign ram_rx_valid = rxv_q;
  assign m0_done      = done_q[0];
  assign m1_done      = done_q[1];
  assign m0_rdata     = rdata_q[0];
  assign m1_rdata     = rdata_q[1];
  assign m0_err       = err_q[0];
  assign m1_err       = err_q[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural RAM model.
module tb_ram_port_arbiter;

  typedef struct {
    logic [9:0] word;
    int         cyc;
  } cmd_t;

  typedef struct {
    int         port;
    logic       wr;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } rsp_t;

  logic       CLK;
  logic       rst;
  logic       m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_done, m0_err, m1_done, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = 8'h00;
  logic       ram_tx_valid = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cmd_t cq[$];
  rsp_t rq[$];
  logic [7:0] ref_mem [256];
  logic [7:0] mem [256];
  logic [7:0] m_waddr, m_raddr, rd_val;
  logic       rd_pend = 1'b0;
  logic       mute = 1'b0;
  logic       stray = 1'b0;
  logic [7:0] stray_data = 8'hAA;
  logic       prev0 = 1'b0, prev1 = 1'b0;

  ram_port_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(4)) dut (
    .CLK(CLK), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // RAM model: decodes command words, answers a read one cycle after the read-data word.
  always @(negedge CLK) begin
    rd_pend = 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: m_waddr = ram_din[7:0];
        2'b01: mem[m_waddr] = ram_din[7:0];
        2'b10: m_raddr = ram_din[7:0];
        default: begin
          rd_pend = !mute;
          rd_val  = mem[m_raddr];
        end
      endcase
    end
  end

  always begin
    @(posedge CLK);
    #1;
    ram_tx_valid = rd_pend | stray;
    ram_dout     = stray ? stray_data : rd_val;
  end

  // Monitor: compares command words and completions against the scoreboard.
  always @(negedge CLK) begin
    cmd_t c;
    rsp_t r;
    if (ram_rx_valid) begin
      if (cq.size() == 0) begin
        check("rxv_unexpected", 32'(ram_rx_valid), 32'd0);
      end else begin
        c = cq.pop_front();
        check("ram_din", 32'(ram_din), 32'(c.word));
        check("din_cycle", cyc, c.cyc);
      end
    end
    if (m0_done || m1_done) begin
      if (rq.size() == 0) begin
        check("done_unexpected", 32'({m1_done, m0_done}), 32'd0);
      end else begin
        r = rq.pop_front();
        $display("txn port=%0d wr=%0d done at cycle %0d rdata0=%h rdata1=%h err=%b%b",
                 r.port, r.wr, cyc, m0_rdata, m1_rdata, m1_err, m0_err);
        check("done_port", 32'({m1_done, m0_done}), (r.port == 1) ? 32'd2 : 32'd1);
        check("done_cycle", cyc, r.cyc);
        check("err", 32'((r.port == 1) ? m1_err : m0_err), 32'(r.err));
        if (!r.wr) check("rdata", 32'((r.port == 1) ? m1_rdata : m0_rdata), 32'(r.rdata));
      end
    end
    if (prev0) check("err_clear0", 32'(m0_err), 32'd0);
    if (prev1) check("err_clear1", 32'(m1_err), 32'd0);
    prev0 = m0_done;
    prev1 = m1_done;
  end

  // Push expected words and completion for a transaction sampled at edge e; returns done cycle.
  function automatic int push_txn(input int port, input logic wr, input logic [7:0] addr,
                                  input logic [7:0] wd, input int e, input logic no_rsp);
    rsp_t r;
    cq.push_back('{{wr ? 2'b00 : 2'b10, addr}, e + 1});
    cq.push_back('{{wr ? 2'b01 : 2'b11, wr ? wd : 8'h00}, e + 2});
    r.port = port;
    r.wr   = wr;
    if (wr) begin
      ref_mem[addr] = wd;
      r.rdata = 8'h00;
      r.err   = 1'b0;
      r.cyc   = e + 3;
    end else if (no_rsp) begin
      r.rdata = 8'h00;
      r.err   = 1'b1;
      r.cyc   = e + 8;
    end else begin
      r.rdata = ref_mem[addr];
      r.err   = 1'b0;
      r.cyc   = e + 5;
    end
    rq.push_back(r);
    return r.cyc;
  endfunction

  task automatic set_req(input int port, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    if (port == 0) begin
      m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  // Wait for n completions; drop each port's req at its done unless hold is set.
  task automatic run_until(input int n, input int budget, input logic hold);
    int seen = 0;
    for (int k = 0; k < budget && seen < n; k++) begin
      @(negedge CLK);
      if (m0_done) begin seen++; if (!hold) m0_req = 1'b0; end
      if (m1_done) begin seen++; if (!hold) m1_req = 1'b0; end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("done_count", seen, n);
  endtask

  task automatic to_edge(input int k);
    while (cyc < k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int e, d;
    rst = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
    @(negedge CLK);
    check("rst_din", 32'(ram_din), 32'd0);
    check("rst_rxv", 32'(ram_rx_valid), 32'd0);
    check("rst_done", 32'({m1_done, m0_done}), 32'd0);
    check("rst_rdata", 32'({m1_rdata, m0_rdata}), 32'd0);
    check("rst_err", 32'({m1_err, m0_err}), 32'd0);

    // port 0 write
    @(posedge CLK); #1;
    set_req(0, 1'b1, 8'h2A, 8'hF0);
    e = cyc + 1;
    d = push_txn(0, 1'b1, 8'h2A, 8'hF0, e, 1'b0);
    run_until(1, 20, 1'b0);

    // port 1 read back
    @(posedge CLK); #1;
    set_req(1, 1'b0, 8'h2A, 8'h00);
    e = cyc + 1;
    d = push_txn(1, 1'b0, 8'h2A, 8'h00, e, 1'b0);
    run_until(1, 20, 1'b0);

    // stray ram_tx_valid while idle
    @(posedge CLK); #2 stray = 1'b1;
    @(posedge CLK); #2 stray = 1'b0;
    repeat (4) @(negedge CLK);
    check("stray_rdata1", 32'(m1_rdata), 32'hF0);
    check("stray_rdata0", 32'(m0_rdata), 32'h00);

    // read timeout on port 1
    mute = 1'b1;
    @(posedge CLK); #1;
    set_req(1, 1'b0, 8'h2A, 8'h00);
    e = cyc + 1;
    d = push_txn(1, 1'b0, 8'h2A, 8'h00, e, 1'b1);
    run_until(1, 30, 1'b0);
    mute = 1'b0;

    // tie held for four transactions: grants 0,1,0,1
    @(posedge CLK); #1;
    set_req(0, 1'b1, 8'h10, 8'h11);
    set_req(1, 1'b1, 8'h20, 8'h22);
    e = cyc + 1;
    d = push_txn(0, 1'b1, 8'h10, 8'h11, e, 1'b0);
    d = push_txn(1, 1'b1, 8'h20, 8'h22, d + 1, 1'b0);
    d = push_txn(0, 1'b1, 8'h10, 8'h11, d + 1, 1'b0);
    d = push_txn(1, 1'b1, 8'h20, 8'h22, d + 1, 1'b0);
    run_until(4, 40, 1'b1);

    // reset during DATA of a write: only the ADDR word is expected, no done
    @(posedge CLK); #1;
    set_req(0, 1'b1, 8'h55, 8'h66);
    e = cyc + 1;
    cq.push_back('{{2'b00, 8'h55}, e + 1});
    to_edge(e + 1);
    rst = 1'b1;
    m0_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_rxv", 32'(ram_rx_valid), 32'd0);
    check("abort_din", 32'(ram_din), 32'd0);
    check("abort_done", 32'({m1_done, m0_done}), 32'd0);
    check("abort_rdata1", 32'(m1_rdata), 32'd0);
    @(posedge CLK); #1 rst = 1'b0;
    repeat (4) @(negedge CLK);

    // tie after reset: port 0 first
    @(posedge CLK); #1;
    set_req(0, 1'b0, 8'h10, 8'h00);
    set_req(1, 1'b1, 8'h33, 8'h44);
    e = cyc + 1;
    d = push_txn(0, 1'b0, 8'h10, 8'h00, e, 1'b0);
    d = push_txn(1, 1'b1, 8'h33, 8'h44, d + 1, 1'b0);
    run_until(2, 30, 1'b0);

    repeat (4) @(negedge CLK);
    check("scoreboard_empty", cq.size() + rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and command sequencer for the single-port 256x8 RAM behind the SPI slave.
- Accepts whole-word read/write transactions from two requesters: port 0 is the SPI slave path, port 1 is the debug/host path.
- Grants one requester at a time, round-robin.
- Serialises each transaction into the RAM's two-word 10-bit command protocol on `ram_din`/`ram_rx_valid`.
- Returns read data from `ram_dout`/`ram_tx_valid`.

## Interface
- `ADDR_SIZE`, default 8: RAM address width, which is also the RAM data width.
- `RD_TIMEOUT`, default 4: maximum number of cycles spent waiting for `ram_tx_valid` after the read-data command.
- `CLK` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m0_req`, `m1_req` in 1: transaction request, held until `mX_done`.
- `m0_wr`, `m1_wr` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in ADDR_SIZE: target address.
- `m0_wdata`, `m1_wdata` in 8: write data; ignored for reads.
- `m0_done`, `m1_done` out 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` out 8: read data; valid while `mX_done` is high.
- `m0_err`, `m1_err` out 1: read timeout flag; valid while `mX_done` is high.
- `ram_din` out 10: RAM command word, formatted as {opcode[1:0], payload[7:0]}.
- `ram_rx_valid` out 1: command word valid.
- `ram_dout` in 8: RAM read data.
- `ram_tx_valid` in 1: RAM read data valid.

## Operation
- All outputs are registered. Reset values:
  - `ram_din` = 0, `ram_rx_valid` = 0.
  - `mX_done` = 0, `mX_rdata` = 0, `mX_err` = 0.
  - State = IDLE, last-grant pointer = 1, so port 0 wins the first tie.
- Opcodes:
  - 00 write address, 01 write data.
  - 10 read address, 11 read data (payload 8'h00).
- FSM states: IDLE, ADDR, DATA, WAIT_RD, DONE.
- IDLE:
  - Requests are sampled only in this state.
  - With one request high, that port is granted.
  - With both high, the port not granted last is granted.
  - On grant, wr/addr/wdata are latched and the FSM goes to ADDR.
  - With no request, it stays in IDLE.
- ADDR: drive {wr ? 00 : 10, addr} with `ram_rx_valid` = 1, then go to DATA.
- DATA: drive {wr ? 01 : 11, wr ? wdata : 8'h00} with `ram_rx_valid` = 1.
  - Write: go to DONE.
  - Read: go to WAIT_RD and clear the timeout counter.
- WAIT_RD: `ram_rx_valid` = 0; the counter increments each cycle.
  - On `ram_tx_valid` = 1: capture `ram_dout` into the granted port's rdata and go to DONE.
  - When the counter reaches RD_TIMEOUT with no `ram_tx_valid`: rdata = 0, err = 1, go to DONE.
- DONE:
  - Pulse the granted port's `done` for exactly one cycle.
  - rdata/err are held valid alongside `done`, then err clears.
  - Update the last-grant pointer and go to IDLE.
- `ram_tx_valid` outside WAIT_RD is ignored.
- Changes to the non-granted port's request fields during a transaction have no effect.
- The requester must drop `req` in the cycle `done` is high. A `req` still high at the next IDLE sample is a new transaction.
- Address/data are passed through unmodified; no wrap logic is needed because `ADDR_SIZE` matches the RAM depth.

## Timing
- Let E be the edge at which IDLE samples a granted request.
- ADDR word is valid E+1..E+2; DATA word is valid E+2..E+3.
- Write: `done` is high E+3..E+4, so write latency is 3 cycles.
- Read: `ram_tx_valid` is sampled from edge E+3 onward. `done` rises on the edge after capture, giving minimum read latency of 4 cycles and maximum of 3+RD_TIMEOUT+1.
- Back-to-back: after DONE, one IDLE cycle before the next ADDR, so throughput is 1 write per 4 cycles.
- `ram_rx_valid` is high for exactly 2 consecutive cycles per transaction and never otherwise.
- `rst` asserted in any state:
  - At the next edge: IDLE, all outputs at reset values.
  - No `done` pulse for the aborted transaction, and no further RAM command words.

## Structure
- `ram_ctrl_pkg`:
  - State enum `arb_state_e`.
  - Opcode constants `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`.
  - Shared by the RAM and SPI slave.
- Sub-module `rr_arb2`: 2-way round-robin grant logic.
  - Inputs: `req[1:0]`, `last`.
  - Output: one-hot `gnt[1:0]`.
  - Combinational; the pointer register stays in the parent.
- FSM, command formatting, timeout counter and response registers live in `ram_port_arbiter`.

## Test plan
- Port 0 write addr 8'h2A, data 8'hF0 → `ram_din` 10'b00_0010_1010 at E+1, 10'b01_1111_0000 at E+2; `m0_done` at E+3; `m0_err` = 0.
- Port 1 read addr 8'h2A, RAM model returns 8'hF0 one cycle after the read-data word → `m1_rdata` = 8'hF0 with `m1_done`, `m1_err` = 0.
- Both ports request writes at the same edge, held continuously → grants alternate 0,1,0,1 across four transactions; each ADDR starts one IDLE cycle after the previous DONE.
- Read with `ram_tx_valid` held low, `RD_TIMEOUT` = 4 → `done` with err = 1 and rdata = 0 at E+8.
- `rst` asserted during DATA of a write → next edge `ram_rx_valid` = 0, no `done`; a subsequent tie grants port 0.
- Stray `ram_tx_valid` pulse in IDLE → no `done`, no rdata change.
